// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction/data requester ports and the shared SSRAM port.
interface mem_arbiter_if #(parameter int MEM_AW = 10);
   logic [31:0]       instr_address;
   logic              instr_enable;
   logic [31:0]       instr_data;
   logic              instr_rdy;
   logic [31:0]       data_address;
   logic              data_read_enable;
   logic [31:0]       data_read_data;
   logic              data_read_rdy;
   logic              data_write_enable;
   logic [3:0]        data_write_byte_enable;
   logic [31:0]       data_write_data;
   logic              data_write_rdy;
   logic [MEM_AW-1:0] mem_address;
   logic              mem_read_enable;
   logic              mem_write_enable;
   logic [3:0]        mem_write_byte_enable;
   logic [31:0]       mem_write_data;
   logic [31:0]       mem_read_data;
   modport slave (
      input  instr_address, instr_enable, data_address, data_read_enable,
             data_write_enable, data_write_byte_enable, data_write_data, mem_read_data,
      output instr_data, instr_rdy, data_read_data, data_read_rdy, data_write_rdy,
             mem_address, mem_read_enable, mem_write_enable, mem_write_byte_enable, mem_write_data
   );
   modport master (
      output instr_address, instr_enable, data_address, data_read_enable,
             data_write_enable, data_write_byte_enable, data_write_data, mem_read_data,
      input  instr_data, instr_rdy, data_read_data, data_read_rdy, data_write_rdy,
             mem_address, mem_read_enable, mem_write_enable, mem_write_byte_enable, mem_write_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port SSRAM between instruction and data requesters.
module mem_arbiter #(
   parameter int MEM_AW = 10
) (
   input  logic        clk,
   input  logic        rst,
   mem_arbiter_if.slave bus,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t            r_state, w_next;
   logic              r_last_data, r_gnt_data, r_is_write;
   logic [MEM_AW-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_be;
   logic              w_req_i, w_req_d, w_pick_d, w_issue, w_resp, w_unused;
   assign w_req_i  = bus.instr_enable;
   assign w_req_d  = bus.data_read_enable | bus.data_write_enable;
   // data wins if it is alone, or on a tie when instruction was granted last
   assign w_pick_d = w_req_d & (~w_req_i | ~r_last_data);
   assign w_unused = ^{bus.instr_address[31:MEM_AW+2], bus.instr_address[1:0],
                       bus.data_address[31:MEM_AW+2], bus.data_address[1:0]};
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_last_data <= 1'b1;
         r_gnt_data  <= 1'b0;
         r_is_write  <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && (w_req_i || w_req_d)) begin
            r_last_data <= w_pick_d;
            r_gnt_data  <= w_pick_d;
            r_is_write  <= w_pick_d & bus.data_write_enable;
            r_addr      <= w_pick_d ? bus.data_address[MEM_AW+1:2] : bus.instr_address[MEM_AW+1:2];
            r_wdata     <= bus.data_write_data;
            r_be        <= bus.data_write_byte_enable;
         end
      end
   end
   always_comb begin
      w_issue                   = r_state == ISSUE;
      w_resp                    = r_state == RESP;
      w_next                    = r_state == IDLE ? ((w_req_i || w_req_d) ? ISSUE : IDLE)
                                                  : (w_issue ? RESP : IDLE);
      busy                      = r_state != IDLE;
      bus.mem_address           = r_addr;
      bus.mem_write_data        = r_wdata;
      bus.mem_read_enable       = w_issue & ~r_is_write;
      bus.mem_write_enable      = w_issue & r_is_write;
      bus.mem_write_byte_enable = (w_issue & r_is_write) ? r_be : 4'b0000;
      bus.instr_rdy             = w_resp & ~r_gnt_data;
      bus.data_read_rdy         = w_resp & r_gnt_data & ~r_is_write;
      bus.data_write_rdy        = w_resp & r_gnt_data & r_is_write;
      bus.instr_data            = bus.instr_rdy ? bus.mem_read_data : 32'h0;
      bus.data_read_data        = bus.data_read_rdy ? bus.mem_read_data : 32'h0;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against a transaction-level model with an SSRAM model attached.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   int   tests = 0;
   int   fails = 0;
   mem_arbiter_if #(.MEM_AW(10)) b();
   mem_arbiter #(.MEM_AW(10)) dut (.clk(clk), .rst(rst), .bus(b), .busy(busy));
   always #5 clk = ~clk;

   logic [31:0] ssram   [1024];
   logic [31:0] ref_mem [1024];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (b.mem_write_enable && b.mem_write_byte_enable[i])
            ssram[b.mem_address][8*i +: 8] <= b.mem_write_data[8*i +: 8];
      if (b.mem_read_enable) b.mem_read_data <= ssram[b.mem_address];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 memory strobe, 2 response
   int          m_phase = 0;
   int          m_addr = 0;
   bit          m_last_d = 1'b1, m_d = 1'b0, m_w = 1'b0, m_valid = 1'b0;
   logic [31:0] m_wd = '0;
   logic [3:0]  m_be = '0;
   always @(posedge clk) begin
      if (m_phase == 1 && m_w)
         for (int i = 0; i < 4; i++) if (m_be[i]) ref_mem[m_addr][8*i +: 8] = m_wd[8*i +: 8];
      if (rst) begin
         m_phase = 0; m_last_d = 1'b1; m_valid = 1'b1;
      end else if (m_phase == 0) begin
         if (b.instr_enable || b.data_read_enable || b.data_write_enable) begin
            m_d      = (b.data_read_enable || b.data_write_enable) && (!b.instr_enable || !m_last_d);
            m_last_d = m_d;
            m_w      = m_d && b.data_write_enable;
            m_addr   = int'(((m_d ? b.data_address : b.instr_address) >> 2) % 1024);
            m_wd     = b.data_write_data;
            m_be     = b.data_write_byte_enable;
            m_phase  = 1;
         end
      end else m_phase = (m_phase + 1) % 3;
   end

   always @(negedge clk) if (m_valid) begin
      chk("busy", busy, m_phase != 0);
      chk("mem_re", b.mem_read_enable, m_phase == 1 && !m_w);
      chk("mem_we", b.mem_write_enable, m_phase == 1 && m_w);
      chk("mem_be", b.mem_write_byte_enable, (m_phase == 1 && m_w) ? m_be : 4'h0);
      if (m_phase == 1) chk("mem_addr", b.mem_address, m_addr);
      if (m_phase == 1 && m_w) chk("mem_wdata", b.mem_write_data, m_wd);
      chk("instr_rdy", b.instr_rdy, m_phase == 2 && !m_d);
      chk("rd_rdy", b.data_read_rdy, m_phase == 2 && m_d && !m_w);
      chk("wr_rdy", b.data_write_rdy, m_phase == 2 && m_d && m_w);
      chk("instr_data", b.instr_data, (m_phase == 2 && !m_d) ? ref_mem[m_addr] : 32'h0);
      chk("rd_data", b.data_read_data, (m_phase == 2 && m_d && !m_w) ? ref_mem[m_addr] : 32'h0);
   end

   task automatic nxt();
      @(posedge clk); @(negedge clk);
   endtask
   task automatic edge1();
      @(posedge clk); #1;
   endtask

   logic [11:0] ivec, dvec;
   initial begin
      for (int i = 0; i < 1024; i++) begin ssram[i] = 32'hFFFF_FFFF; ref_mem[i] = 32'hFFFF_FFFF; end
      ssram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
      ssram[8] = 32'h0000_8888; ref_mem[8] = 32'h0000_8888;
      b.instr_address = '0; b.instr_enable = 0; b.data_address = '0; b.data_read_enable = 0;
      b.data_write_enable = 0; b.data_write_byte_enable = '0; b.data_write_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      b.instr_enable = 1; b.instr_address = 32'h10;
      nxt(); chk("fetch_addr", b.mem_address, 4); chk("fetch_re", b.mem_read_enable, 1);
      nxt(); chk("fetch_rdy", b.instr_rdy, 1); chk("fetch_data", b.instr_data, 32'hDEAD_BEEF);
      edge1(); b.instr_address = 32'h1004;
      nxt(); chk("wrap_addr", b.mem_address, 1);
      nxt(); chk("wrap_rdy", b.instr_rdy, 1);
      edge1(); b.instr_enable = 0;
      b.data_write_enable = 1; b.data_address = 32'h40; b.data_write_data = 32'h1234_5678;
      b.data_write_byte_enable = 4'b0011;
      nxt(); nxt(); chk("wr_pulse", b.data_write_rdy, 1);
      edge1(); b.data_write_enable = 0; b.data_read_enable = 1;
      nxt(); nxt(); chk("rd_after_wr", b.data_read_data, 32'hFFFF_5678);
      edge1(); b.data_read_enable = 0; b.data_write_enable = 1;
      b.data_write_byte_enable = 4'b0000; b.data_write_data = 32'h0;
      nxt(); chk("be0_we", b.mem_write_enable, 1);
      nxt(); chk("be0_rdy", b.data_write_rdy, 1);
      edge1(); b.data_read_enable = 1; b.data_address = 32'h80;
      b.data_write_data = 32'hA5A5_0F0F; b.data_write_byte_enable = 4'hF;
      nxt(); chk("wfirst_we", b.mem_write_enable, 1);
      nxt(); chk("wfirst_wr", b.data_write_rdy, 1); chk("wfirst_rd", b.data_read_rdy, 0);
      edge1(); b.data_write_enable = 0;
      nxt(); nxt(); chk("rd_new_rdy", b.data_read_rdy, 1); chk("rd_new", b.data_read_data, 32'hA5A5_0F0F);
      edge1(); b.data_read_enable = 0;
      rst = 1;
      edge1(); rst = 0;
      b.instr_enable = 1; b.instr_address = 32'h10; b.data_read_enable = 1; b.data_address = 32'h40;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); ivec[k] = b.instr_rdy; dvec[k] = b.data_read_rdy;
      end
      edge1(); b.data_read_enable = 0; b.instr_address = 32'h20;
      chk("rr_instr", {20'h0, ivec}, 32'h104);
      chk("rr_data", {20'h0, dvec}, 32'h820);
      nxt(); chk("abort_issue", b.mem_read_enable, 1);
      rst = 1;
      edge1(); rst = 0;
      @(negedge clk);
      chk("abort_busy", busy, 0); chk("abort_rdy", b.instr_rdy, 0);
      chk("abort_re", b.mem_read_enable, 0); chk("abort_addr", b.mem_address, 0);
      nxt(); nxt(); chk("regrant_rdy", b.instr_rdy, 1); chk("regrant_data", b.instr_data, 32'h0000_8888);
      edge1(); b.instr_enable = 0;
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
